// File: rtl/spi_frame_slave_pkg.sv
// Shared types and helpers for the SPI frame slave: FSM state encoding,
// synchroniser depth and the CPOL/CPHA sample-edge select.
package spi_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        OVERRUN
    } spi_state_t;

    // Data is sampled on the rising sck edge when CPOL equals CPHA.
    function automatic logic sample_on_rise(input logic cpol, input logic cpha);
        return cpol == cpha;
    endfunction

endpackage

// File: rtl/spi_frame_slave_sync_edge.sv
// Multi-flop synchroniser for an asynchronous SPI pin, with a history flop
// producing one-clk rise/fall pulses on the synchronised level.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= RST_VAL ? '1 : '0;
            hist_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = q_o & ~hist_q;
    assign fall_o = ~q_o & hist_q;

endmodule

// File: rtl/spi_frame_slave.sv
// Oversampling SPI slave assembling frames of up to MAX_WORDS words, with reply shifting on sdo.
// Build option SPI_FRAME_HOLD_EN adds frame_data, updated atomically on each error-free frame.
module spi_frame_slave
    import spi_pkg::*;
#(
    parameter int WORD_W    = 8,
    parameter int MAX_WORDS = 2,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             sck,
    input  logic                             sdi,
    input  logic                             nss,
    output logic                             sdo,
    output logic [WORD_W-1:0]                rx_word,
    output logic                             rx_valid,
    output logic [$clog2(MAX_WORDS+1)-1:0]   rx_index,
    output logic                             frame_done,
    output logic [$clog2(MAX_WORDS+1)-1:0]   frame_words,
    output logic                             frame_err,
    input  logic [WORD_W-1:0]                tx_word,
    output logic                             tx_ready
`ifdef SPI_FRAME_HOLD_EN
    ,output logic [MAX_WORDS*WORD_W-1:0]     frame_data
`endif
);

    localparam int CW          = $clog2(MAX_WORDS + 1);
    localparam int BW          = $clog2(WORD_W + 1);
    localparam int HW          = $clog2(SYNC_STAGES + 1);
    localparam bit SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

    logic sck_s, sck_rise, sck_fall;
    logic nss_s, nss_rise, nss_fall;
    logic [SYNC_STAGES-1:0] sdi_sync_q;
    logic sdi_s;

    spi_sync_edge #(.RST_VAL(CPOL)) u_sck_sync (
        .clk(clk), .rst(rst), .d_i(sck), .q_o(sck_s), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_nss_sync (
        .clk(clk), .rst(rst), .d_i(nss), .q_o(nss_s), .rise_o(nss_rise), .fall_o(nss_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) sdi_sync_q <= '0;
        else     sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
    end
    assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

    spi_state_t        state_q;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]     word_cnt_q, word_cnt_d;
    logic [WORD_W-1:0] rx_shift_q, rx_shift_d;
    logic [WORD_W-1:0] tx_shift_q;
    logic [WORD_W-1:0] rx_word_q;
    logic [CW-1:0]     rx_index_q, frame_words_q;
    logic              sdo_q, rx_valid_q, frame_done_q, frame_err_q, tx_ready_q;
    logic [HW-1:0]     hold_q;
    logic              armed_q;

    logic sck_edge, sample_edge, shift_edge;
    logic in_active, full, accept, ovr_now, word_end, reload, start, err_d;

    assign sck_edge    = sck_rise | sck_fall;
    assign sample_edge = sck_edge & (sck_s == SAMPLE_RISE);
    assign shift_edge  = sck_edge & (sck_s != SAMPLE_RISE);

    always_comb begin
        in_active  = state_q == ACTIVE;
        full       = word_cnt_q == CW'(MAX_WORDS);
        accept     = in_active && sample_edge && !full;
        ovr_now    = in_active && sample_edge && full;
        word_end   = accept && (bit_cnt_q == BW'(WORD_W - 1));
        start      = (state_q == IDLE) && nss_fall && armed_q;
        rx_shift_d = {rx_shift_q[WORD_W-2:0], sdi_s};
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        if (word_end) begin
            bit_cnt_d  = '0;
            word_cnt_d = word_cnt_q + CW'(1);
        end else if (accept) begin
            bit_cnt_d = bit_cnt_q + BW'(1);
        end
        reload = in_active && shift_edge && (bit_cnt_q == '0) && (word_cnt_q != '0) && !full;
        err_d  = (bit_cnt_d != '0) || ovr_now;
    end

    // The nss synchroniser resets high, so a pin already low at reset release would look like
    // a falling edge; starts are only accepted once nss has been seen high after the holdoff.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            word_cnt_q    <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            sdo_q         <= 1'b0;
            rx_word_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_index_q    <= '0;
            frame_done_q  <= 1'b0;
            frame_words_q <= '0;
            frame_err_q   <= 1'b0;
            tx_ready_q    <= 1'b0;
            hold_q        <= HW'(SYNC_STAGES);
            armed_q       <= 1'b0;
        end else begin
            rx_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            tx_ready_q   <= 1'b0;
            if (hold_q != '0) hold_q <= hold_q - HW'(1);
            if (hold_q == '0 && nss_s) armed_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= ACTIVE;
                        bit_cnt_q  <= '0;
                        word_cnt_q <= '0;
                        tx_ready_q <= 1'b1;
                        if (CPHA) begin
                            sdo_q      <= 1'b0;
                            tx_shift_q <= tx_word;
                        end else begin
                            {sdo_q, tx_shift_q} <= {tx_word, 1'b0};
                        end
                    end
                end
                ACTIVE: begin
                    bit_cnt_q  <= bit_cnt_d;
                    word_cnt_q <= word_cnt_d;
                    if (accept) rx_shift_q <= rx_shift_d;
                    if (word_end) begin
                        rx_word_q  <= rx_shift_d;
                        rx_valid_q <= 1'b1;
                        rx_index_q <= word_cnt_q;
                    end
                    if (reload) begin
                        {sdo_q, tx_shift_q} <= {tx_word, 1'b0};
                        tx_ready_q          <= 1'b1;
                    end else if (shift_edge) begin
                        {sdo_q, tx_shift_q} <= {tx_shift_q, 1'b0};
                    end
                    if (nss_rise) begin
                        state_q       <= IDLE;
                        sdo_q         <= 1'b0;
                        frame_done_q  <= 1'b1;
                        frame_words_q <= word_cnt_d;
                        frame_err_q   <= err_d;
                    end else if (ovr_now) begin
                        state_q <= OVERRUN;
                        sdo_q   <= 1'b0;
                    end
                end
                OVERRUN: begin
                    sdo_q <= 1'b0;
                    if (nss_rise) begin
                        state_q       <= IDLE;
                        frame_done_q  <= 1'b1;
                        frame_words_q <= word_cnt_q;
                        frame_err_q   <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sdo         = sdo_q;
    assign rx_word     = rx_word_q;
    assign rx_valid    = rx_valid_q;
    assign rx_index    = rx_index_q;
    assign frame_done  = frame_done_q;
    assign frame_words = frame_words_q;
    assign frame_err   = frame_err_q;
    assign tx_ready    = tx_ready_q;

`ifdef SPI_FRAME_HOLD_EN
    logic [MAX_WORDS*WORD_W-1:0] frame_buf_q, frame_buf_d, frame_data_q;

    always_comb begin
        frame_buf_d = frame_buf_q;
        if (word_end) frame_buf_d[int'(word_cnt_q)*WORD_W +: WORD_W] = rx_shift_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_buf_q  <= '0;
            frame_data_q <= '0;
        end else if (start) begin
            frame_buf_q <= '0;
        end else if (in_active) begin
            frame_buf_q <= frame_buf_d;
            if (nss_rise && !err_d) frame_data_q <= frame_buf_d;
        end
    end

    assign frame_data = frame_data_q;
`endif

endmodule

// File: tb/tb_spi_frame_slave.sv
// Directed bench for spi_frame_slave: mode 0 instance for framing/overrun/reset scenarios,
// mode 3 (CPOL=1, CPHA=1) instance for reply shifting on the alternate edge pairing.
module tb_spi_frame_slave;

    localparam int HALF = 8;

    logic clk, rst;
    logic sck0, sdi0, nss0, sdo0, rx_valid0, frame_done0, frame_err0, tx_ready0;
    logic [7:0] rx_word0, tx_word0;
    logic [1:0] rx_index0, frame_words0;
    logic sck1, sdi1, nss1, sdo1, rx_valid1, frame_done1, frame_err1, tx_ready1;
    logic [7:0] rx_word1, tx_word1;
    logic [1:0] rx_index1, frame_words1;
`ifdef SPI_FRAME_HOLD_EN
    logic [15:0] frame_data0, frame_data1;
`endif

    int passed = 0;
    int total  = 0;

    spi_frame_slave #(.WORD_W(8), .MAX_WORDS(2), .CPOL(1'b0), .CPHA(1'b0)) dut0 (
        .clk(clk), .rst(rst), .sck(sck0), .sdi(sdi0), .nss(nss0), .sdo(sdo0),
        .rx_word(rx_word0), .rx_valid(rx_valid0), .rx_index(rx_index0),
        .frame_done(frame_done0), .frame_words(frame_words0), .frame_err(frame_err0),
        .tx_word(tx_word0), .tx_ready(tx_ready0)
`ifdef SPI_FRAME_HOLD_EN
        , .frame_data(frame_data0)
`endif
    );

    spi_frame_slave #(.WORD_W(8), .MAX_WORDS(2), .CPOL(1'b1), .CPHA(1'b1)) dut1 (
        .clk(clk), .rst(rst), .sck(sck1), .sdi(sdi1), .nss(nss1), .sdo(sdo1),
        .rx_word(rx_word1), .rx_valid(rx_valid1), .rx_index(rx_index1),
        .frame_done(frame_done1), .frame_words(frame_words1), .frame_err(frame_err1),
        .tx_word(tx_word1), .tx_ready(tx_ready1)
`ifdef SPI_FRAME_HOLD_EN
        , .frame_data(frame_data1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] rxw0[$];
    logic [1:0] rxi0[$];
    int         ndone0 = 0, nready0 = 0;
    logic [1:0] fw0;
    logic       fe0;
    time        tvalid0;
    logic [7:0] rxw1[$];
    logic [1:0] rxi1[$];
    int         ndone1 = 0, nready1 = 0;
    logic [1:0] fw1;
    logic       fe1;
    time        t_edge0;

    always @(negedge clk) begin
        if (rx_valid0) begin
            rxw0.push_back(rx_word0);
            rxi0.push_back(rx_index0);
            tvalid0 = $time;
        end
        if (frame_done0) begin
            ndone0++;
            fw0 = frame_words0;
            fe0 = frame_err0;
        end
        if (tx_ready0) nready0++;
        if (rx_valid1) begin
            rxw1.push_back(rx_word1);
            rxi1.push_back(rx_index1);
        end
        if (frame_done1) begin
            ndone1++;
            fw1 = frame_words1;
            fe1 = frame_err1;
        end
        if (tx_ready1) nready1++;
    end

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // Mode 0 master: data set on falling sck, slave and master sample on rising sck.
    task automatic m0_bits(input logic [7:0] d, input int unsigned nbits, output logic [7:0] miso);
        miso = '0;
        for (int unsigned i = 0; i < nbits; i++) begin
            sdi0 = d[7-i];
            wait_clks(HALF);
            miso = {miso[6:0], sdo0};
            sck0 = 1'b1;
            t_edge0 = $time;
            wait_clks(HALF);
            sck0 = 1'b0;
        end
    endtask

    task automatic m0_begin();
        nss0 = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic m0_end();
        wait_clks(HALF);
        nss0 = 1'b1;
        wait_clks(12);
    endtask

    task automatic test_reset();
        total++; if (rx_word0 !== 8'h00) $display("FAIL reset_rx_word: got %0h want 0", rx_word0); else passed++;
        total++; if (rx_valid0 !== 1'b0) $display("FAIL reset_rx_valid: got %0b want 0", rx_valid0); else passed++;
        total++; if (rx_index0 !== 2'd0) $display("FAIL reset_rx_index: got %0d want 0", rx_index0); else passed++;
        total++; if (frame_done0 !== 1'b0) $display("FAIL reset_frame_done: got %0b want 0", frame_done0); else passed++;
        total++; if (frame_words0 !== 2'd0) $display("FAIL reset_frame_words: got %0d want 0", frame_words0); else passed++;
        total++; if (frame_err0 !== 1'b0) $display("FAIL reset_frame_err: got %0b want 0", frame_err0); else passed++;
        total++; if (tx_ready0 !== 1'b0) $display("FAIL reset_tx_ready: got %0b want 0", tx_ready0); else passed++;
        total++; if (sdo0 !== 1'b0) $display("FAIL reset_sdo0: got %0b want 0", sdo0); else passed++;
        total++; if (sdo1 !== 1'b0) $display("FAIL reset_sdo1: got %0b want 0", sdo1); else passed++;
    endtask

    task automatic test_single_word();
        int b = rxw0.size();
        int d = ndone0;
        logic [7:0] miso;
        tx_word0 = 8'h96;
        m0_begin();
        m0_bits(8'hA5, 8, miso);
        m0_end();
        total++; if (rxw0.size() - b != 1) $display("FAIL single_nvalid: got %0d want 1", rxw0.size() - b); else passed++;
        if (rxw0.size() > b) begin
            total++; if (rxw0[b] !== 8'hA5) $display("FAIL single_rx_word: got %0h want a5", rxw0[b]); else passed++;
            total++; if (rxi0[b] !== 2'd0) $display("FAIL single_rx_index: got %0d want 0", rxi0[b]); else passed++;
        end
        total++; if (tvalid0 - t_edge0 != 30) $display("FAIL single_latency: got %0t want 30", tvalid0 - t_edge0); else passed++;
        total++; if (ndone0 - d != 1) $display("FAIL single_ndone: got %0d want 1", ndone0 - d); else passed++;
        total++; if (fw0 !== 2'd1) $display("FAIL single_frame_words: got %0d want 1", fw0); else passed++;
        total++; if (fe0 !== 1'b0) $display("FAIL single_frame_err: got %0b want 0", fe0); else passed++;
        total++; if (miso !== 8'h96) $display("FAIL single_sdo: got %0h want 96", miso); else passed++;
`ifdef SPI_FRAME_HOLD_EN
        total++; if (frame_data0 !== 16'h00A5) $display("FAIL single_frame_data: got %0h want a5", frame_data0); else passed++;
`endif
    endtask

    task automatic test_two_words();
        int b = rxw0.size();
        int d = ndone0;
        logic [7:0] m_a, m_b;
        tx_word0 = 8'h3C;
        m0_begin();
        m0_bits(8'h12, 8, m_a);
        m0_bits(8'h34, 8, m_b);
        m0_end();
        total++; if (rxw0.size() - b != 2) $display("FAIL two_nvalid: got %0d want 2", rxw0.size() - b); else passed++;
        if (rxw0.size() >= b + 2) begin
            total++; if (rxw0[b] !== 8'h12) $display("FAIL two_word0: got %0h want 12", rxw0[b]); else passed++;
            total++; if (rxi0[b] !== 2'd0) $display("FAIL two_index0: got %0d want 0", rxi0[b]); else passed++;
            total++; if (rxw0[b+1] !== 8'h34) $display("FAIL two_word1: got %0h want 34", rxw0[b+1]); else passed++;
            total++; if (rxi0[b+1] !== 2'd1) $display("FAIL two_index1: got %0d want 1", rxi0[b+1]); else passed++;
        end
        total++; if (ndone0 - d != 1) $display("FAIL two_ndone: got %0d want 1", ndone0 - d); else passed++;
        total++; if (fw0 !== 2'd2) $display("FAIL two_frame_words: got %0d want 2", fw0); else passed++;
        total++; if (fe0 !== 1'b0) $display("FAIL two_frame_err: got %0b want 0", fe0); else passed++;
        total++; if (m_a !== 8'h3C) $display("FAIL two_sdo0: got %0h want 3c", m_a); else passed++;
        total++; if (m_b !== 8'h3C) $display("FAIL two_sdo1: got %0h want 3c", m_b); else passed++;
`ifdef SPI_FRAME_HOLD_EN
        total++; if (frame_data0 !== 16'h3412) $display("FAIL two_frame_data: got %0h want 3412", frame_data0); else passed++;
`endif
    endtask

    task automatic test_overrun();
        int b = rxw0.size();
        int d = ndone0;
        logic [7:0] m_a, m_b, m_c;
        tx_word0 = 8'h3C;
        m0_begin();
        m0_bits(8'h77, 8, m_a);
        m0_bits(8'h88, 8, m_b);
        m0_bits(8'h99, 8, m_c);
        m0_end();
        total++; if (rxw0.size() - b != 2) $display("FAIL ovr_nvalid: got %0d want 2", rxw0.size() - b); else passed++;
        total++; if (ndone0 - d != 1) $display("FAIL ovr_ndone: got %0d want 1", ndone0 - d); else passed++;
        total++; if (fw0 !== 2'd2) $display("FAIL ovr_frame_words: got %0d want 2", fw0); else passed++;
        total++; if (fe0 !== 1'b1) $display("FAIL ovr_frame_err: got %0b want 1", fe0); else passed++;
        total++; if (m_c !== 8'h00) $display("FAIL ovr_sdo: got %0h want 0", m_c); else passed++;
`ifdef SPI_FRAME_HOLD_EN
        total++; if (frame_data0 !== 16'h3412) $display("FAIL ovr_frame_data: got %0h want 3412", frame_data0); else passed++;
`endif
    endtask

    task automatic test_partial();
        int b = rxw0.size();
        int d = ndone0;
        logic [7:0] miso;
        m0_begin();
        m0_bits(8'hFF, 5, miso);
        m0_end();
        total++; if (rxw0.size() - b != 0) $display("FAIL part_nvalid: got %0d want 0", rxw0.size() - b); else passed++;
        total++; if (ndone0 - d != 1) $display("FAIL part_ndone: got %0d want 1", ndone0 - d); else passed++;
        total++; if (fw0 !== 2'd0) $display("FAIL part_frame_words: got %0d want 0", fw0); else passed++;
        total++; if (fe0 !== 1'b1) $display("FAIL part_frame_err: got %0b want 1", fe0); else passed++;
`ifdef SPI_FRAME_HOLD_EN
        total++; if (frame_data0 !== 16'h3412) $display("FAIL part_frame_data: got %0h want 3412", frame_data0); else passed++;
`endif
    endtask

    // Mode 3 master: leading (falling) edge shifts, trailing (rising) edge samples.
    task automatic test_mode11();
        int b = rxw1.size();
        int d = ndone1;
        int r = nready1;
        logic [7:0] miso = '0;
        logic [7:0] dat = 8'hA5;
        tx_word1 = 8'hC3;
        nss1 = 1'b0;
        wait_clks(HALF);
        total++; if (nready1 - r != 1) $display("FAIL m11_tx_ready_at_start: got %0d want 1", nready1 - r); else passed++;
        total++; if (sdo1 !== 1'b0) $display("FAIL m11_sdo_before_shift: got %0b want 0", sdo1); else passed++;
        for (int unsigned i = 0; i < 8; i++) begin
            sck1 = 1'b0;
            sdi1 = dat[7-i];
            wait_clks(HALF);
            miso = {miso[6:0], sdo1};
            sck1 = 1'b1;
            wait_clks(HALF);
        end
        nss1 = 1'b1;
        wait_clks(12);
        total++; if (miso !== 8'hC3) $display("FAIL m11_sdo_stream: got %0h want c3", miso); else passed++;
        total++; if (rxw1.size() - b != 1) $display("FAIL m11_nvalid: got %0d want 1", rxw1.size() - b); else passed++;
        if (rxw1.size() > b) begin
            total++; if (rxw1[b] !== 8'hA5) $display("FAIL m11_rx_word: got %0h want a5", rxw1[b]); else passed++;
            total++; if (rxi1[b] !== 2'd0) $display("FAIL m11_rx_index: got %0d want 0", rxi1[b]); else passed++;
        end
        total++; if (ndone1 - d != 1) $display("FAIL m11_ndone: got %0d want 1", ndone1 - d); else passed++;
        total++; if (fw1 !== 2'd1) $display("FAIL m11_frame_words: got %0d want 1", fw1); else passed++;
        total++; if (fe1 !== 1'b0) $display("FAIL m11_frame_err: got %0b want 0", fe1); else passed++;
        total++; if (nready1 - r != 1) $display("FAIL m11_tx_ready_total: got %0d want 1", nready1 - r); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int b = rxw0.size();
        int d = ndone0;
        logic [7:0] miso;
        tx_word0 = 8'h3C;
        m0_begin();
        m0_bits(8'hC0, 4, miso);
        rst = 1'b1;
        wait_clks(1);
        rst = 1'b0;
        wait_clks(1);
        total++; if (rx_word0 !== 8'h00) $display("FAIL rstmid_rx_word: got %0h want 0", rx_word0); else passed++;
        total++; if (sdo0 !== 1'b0) $display("FAIL rstmid_sdo: got %0b want 0", sdo0); else passed++;
        m0_bits(8'h30, 4, miso);
        m0_end();
        total++; if (rxw0.size() - b != 0) $display("FAIL rstmid_nvalid: got %0d want 0", rxw0.size() - b); else passed++;
        total++; if (ndone0 - d != 0) $display("FAIL rstmid_ndone: got %0d want 0", ndone0 - d); else passed++;
        b = rxw0.size();
        d = ndone0;
        m0_begin();
        m0_bits(8'h5A, 8, miso);
        m0_end();
        total++; if (rxw0.size() - b != 1) $display("FAIL post_nvalid: got %0d want 1", rxw0.size() - b); else passed++;
        if (rxw0.size() > b) begin
            total++; if (rxw0[b] !== 8'h5A) $display("FAIL post_rx_word: got %0h want 5a", rxw0[b]); else passed++;
        end
        total++; if (ndone0 - d != 1) $display("FAIL post_ndone: got %0d want 1", ndone0 - d); else passed++;
        total++; if (fw0 !== 2'd1) $display("FAIL post_frame_words: got %0d want 1", fw0); else passed++;
        total++; if (fe0 !== 1'b0) $display("FAIL post_frame_err: got %0b want 0", fe0); else passed++;
    endtask

    initial begin
        rst = 1'b1;
        sck0 = 1'b0; sdi0 = 1'b0; nss0 = 1'b1; tx_word0 = '0;
        sck1 = 1'b1; sdi1 = 1'b0; nss1 = 1'b1; tx_word1 = '0;
        wait_clks(4);
        test_reset();
        rst = 1'b0;
        wait_clks(6);
        test_single_word();
        test_two_words();
        test_overrun();
        test_partial();
        test_mode11();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/spi_frame_slave.md
Name: spi_frame_slave

Overview:
- Parametrised SPI slave, successor to the single-byte/two-byte shift-register receivers.
- Oversamples sck/sdi/nss in the system clock domain and assembles frames of up to MAX_WORDS words of WORD_W bits.
- Delivers each word with a valid strobe, flags frame completion and length errors, and optionally shifts reply words out on sdo.
- Sits between the MCU SPI pins and application logic (e.g. roll/dice display logic).

Parameters:
- WORD_W, 8: bits per SPI word, MSB first; legal range 2..32.
- MAX_WORDS, 2: maximum words per frame (nss low period); legal range 1..16.
- CPOL, 0: idle level of sck.
- CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge.

Ports:
- clk  in  1  system clock; must be ≥4× sck frequency.
- rst  in  1  reset, synchronous, active-high.
- sck  in  1  SPI clock, asynchronous.
- sdi  in  1  SPI data in (MOSI), asynchronous.
- nss  in  1  SPI chip select, active low, asynchronous.
- sdo  out  1  SPI data out (MISO).
- rx_word  out  WORD_W  last completed received word.
- rx_valid  out  1  one-clk pulse when rx_word updates.
- rx_index  out  $clog2(MAX_WORDS+1)  position of rx_word within the frame, 0-based.
- frame_done  out  1  one-clk pulse on nss rising edge.
- frame_words  out  $clog2(MAX_WORDS+1)  complete words in the just-ended frame; valid with frame_done.
- frame_err  out  1  one-clk pulse with frame_done if bits were left over or word count exceeded MAX_WORDS.
- tx_word  in  WORD_W  next reply word.
- tx_ready  out  1  one-clk pulse when tx_word is captured into the shifter.

Behaviour:
- Synchronisers: sck, sdi and nss each pass through a 2-FF synchroniser, plus one history FF for edge detection. Reset values are sck = CPOL, nss = 1, sdi = 0.
- Sample edge: rising when CPOL == CPHA, else falling. The opposite edge is the shift edge.
- States are IDLE, ACTIVE and OVERRUN.
  - IDLE → ACTIVE on synchronised nss falling edge: bit_cnt = 0, word_cnt = 0, load tx_word into tx_shift, pulse tx_ready.
  - ACTIVE, each sample edge: shift sdi into rx_shift LSB; bit_cnt++.
  - When bit_cnt reaches WORD_W: rx_word ← completed word the next clk, rx_valid = 1, rx_index = word_cnt, bit_cnt = 0, word_cnt++.
  - If word_cnt becomes MAX_WORDS and a further sample edge occurs, go to OVERRUN. OVERRUN discards all data, emits no rx_valid, and drives sdo = 0.
  - ACTIVE/OVERRUN → IDLE on nss rising edge: frame_done pulse; frame_words = word_cnt, saturated at MAX_WORDS.
  - frame_err = (bit_cnt != 0) or OVERRUN.
- Latency: rx_valid is asserted 3 clk after the raw sck sample edge (2 sync stages + 1 register).
- Transmit: sdo = tx_shift MSB while ACTIVE and nss low; 0 in IDLE.
  - CPHA = 0: first bit is presented at nss fall; tx_shift shifts left on each shift edge.
  - CPHA = 1: first bit is presented on the first shift edge.
  - After each word boundary, tx_word is reloaded and tx_ready pulses, provided words remain.
- Edge cases:
  - sck edges while nss is high are ignored.
  - nss rising on the same clk as a word completion: rx_valid and frame_done pulse together, and frame_words includes that word.
  - rst mid-frame: state → IDLE, all counters 0, pulses low, rx_word = 0, sdo = 0. The remainder of the frame is ignored until the next nss falling edge.
- Reset values: rx_word 0, rx_index 0, all pulses 0, frame_words 0, sdo 0.

Optional Feature:
- Macro: SPI_FRAME_HOLD_EN.
- Defined: adds output frame_data [MAX_WORDS*WORD_W-1:0]. Word i is stored at slice i, and the register updates only on a frame_done with no error. This gives atomic multi-byte values such as a 16-bit roll.
- Undefined: the port and its storage are absent; consumers use the rx_valid stream only.

Decomposition:
- Package spi_pkg:
  - typedef spi_state_t {IDLE, ACTIVE, OVERRUN}.
  - Function for the sample-edge select from CPOL/CPHA.
  - Constants SYNC_STAGES = 2.
- One sub-module: spi_sync_edge, a 2-FF synchroniser with rise/fall pulse outputs, instantiated for sck and nss; sdi uses the synchroniser only.

Test Plan:
- Single word: mode 0, WORD_W = 8, MAX_WORDS = 2; send 0xA5 → rx_valid once with rx_word = 0xA5, rx_index = 0; frame_done with frame_words = 1, frame_err = 0.
- Two words: send 0x12, 0x34 in one frame → rx_valid twice (indices 0, 1). With SPI_FRAME_HOLD_EN defined, frame_data = 0x3412 after frame_done.
- Overrun: send 3 bytes with MAX_WORDS = 2 → only 2 rx_valid pulses; frame_done with frame_words = 2, frame_err = 1; frame_data unchanged.
- Partial word: 5 bits then nss high → no rx_valid; frame_err = 1, frame_words = 0.
- Modes: repeat the single-word test for CPOL/CPHA 1/1 with tx_word = 0xC3 → sdo bit stream 1,1,0,0,0,0,1,1 sampled on the master's sample edges; tx_ready pulses at nss fall.
- Reset mid-frame: after 4 bits assert rst for 1 clk, then finish the frame → no rx_valid, no frame_done. The next full frame of 0x5A is received correctly.
